// File: rtl/countdown_scheduler.sv
// Round-robin owner of a single down-counting timer engine shared by NUM_REQ requesters.
// A granted job loads its requester's timeout, counts down on tick, and pulses done on expiry.
module countdown_scheduler #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   load_val,
  input  logic                       tick,
  input  logic                       abort,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [WIDTH-1:0]           count
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;

  logic [NUM_REQ-1:0]   eligible;
  logic [PTR_W-1:0]     idx;
  logic [PTR_W-1:0]     winner;
  logic                 found;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  // Fresh requests look through pending so they can win in the same cycle they arrive.
  always_comb begin
    eligible = pending_q | req;
    found    = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = wrap_add(ptr_q, off);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | req;
    ptr_d     = ptr_q;
    count_d   = count_q;
    grant_d   = grant_q;
    done_d    = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          pending_d[winner] = 1'b0;
          grant_d           = '0;
          grant_d[winner]   = 1'b1;
          count_d           = load_val[int'(winner)*WIDTH +: WIDTH];
          ptr_d             = wrap_add(winner, 1);
          state_d           = RUN;
        end
      end
      RUN: begin
        // Abort outranks expiry, so a cancelled job never reports done.
        if (abort) begin
          state_d = IDLE;
          grant_d = '0;
          count_d = '0;
        end else if (count_q == '0) begin
          state_d = IDLE;
          done_d  = grant_q;
          grant_d = '0;
        end else if (tick) begin
          count_d = count_q - WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      count_q   <= '0;
      grant_q   <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q == RUN);
  assign count = count_q;

endmodule

// File: tb/tb_countdown_scheduler.sv
// Bench for countdown_scheduler: directed scenarios then random traffic, checked against a
// job-level reference model whose predicted grant/done/end events feed an expected queue.
module tb_countdown_scheduler;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int EW      = 16 + 2 + 1 + NUM_REQ + WIDTH;

  localparam logic [1:0] K_GRANT = 2'd1;
  localparam logic [1:0] K_DONE  = 2'd2;
  localparam logic [1:0] K_END   = 2'd3;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] load_val;
  logic                     tick;
  logic                     abort;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [WIDTH-1:0]         count;

  countdown_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst(rst), .req(req), .load_val(load_val), .tick(tick), .abort(abort),
    .grant(grant), .done(done), .busy(busy), .count(count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  int lv[NUM_REQ];
  bit m_pend[NUM_REQ];
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;

  function automatic logic [EW-1:0] pack_evt(input int when, input logic [1:0] kind,
                                              input logic b, input logic [NUM_REQ-1:0] oh,
                                              input int cnt);
    return {16'(when), kind, b, oh, WIDTH'(cnt)};
  endfunction

  task automatic push_evt(input logic [1:0] kind, input logic b, input int who, input int cnt);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[who] = 1'b1;
    exp_q.push_back(pack_evt(cyc + 1, kind, b, oh, cnt));
  endtask

  // Predicts the effect of the coming clock edge given this cycle's inputs.
  task automatic model_step(input logic [NUM_REQ-1:0] rq, input bit tk, input bit ab, input bit rs);
    int w;
    int i;
    if (rs) begin
      if (m_owner >= 0) push_evt(K_END, 1'b0, m_owner, 0);
      m_owner = -1;
      m_cnt   = 0;
      m_ptr   = 0;
      for (int k = 0; k < NUM_REQ; k++) m_pend[k] = 1'b0;
      return;
    end
    if (m_owner < 0) begin
      w = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        i = (m_ptr + k) % NUM_REQ;
        if (w < 0 && (m_pend[i] || rq[i])) w = i;
      end
      for (int k = 0; k < NUM_REQ; k++) m_pend[k] = m_pend[k] || rq[k];
      if (w >= 0) begin
        m_pend[w] = 1'b0;
        m_owner   = w;
        m_cnt     = lv[w];
        m_ptr     = (w + 1) % NUM_REQ;
        push_evt(K_GRANT, 1'b1, w, m_cnt);
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) m_pend[k] = m_pend[k] || rq[k];
      if (ab) begin
        push_evt(K_END, 1'b0, m_owner, 0);
        m_owner = -1;
        m_cnt   = 0;
      end else if (m_cnt == 0) begin
        push_evt(K_DONE, 1'b0, m_owner, 0);
        m_owner = -1;
      end else if (tk) begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [NUM_REQ-1:0] rq, input bit tk, input bit ab, input bit rs);
    @(negedge clk);
    req   = rq;
    tick  = tk;
    abort = ab;
    rst   = rs;
    for (int i = 0; i < NUM_REQ; i++) load_val[i*WIDTH +: WIDTH] = WIDTH'(lv[i]);
    model_step(rq, tk, ab, rs);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  task automatic check_reset_outputs();
    @(posedge clk);
    #1;
    check_val("reset_grant", 32'(grant), 32'd0);
    check_val("reset_done",  32'(done),  32'd0);
    check_val("reset_busy",  32'(busy),  32'd0);
    check_val("reset_count", 32'(count), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check_evt(input string name, input logic [EW-1:0] got);
    logic [EW-1:0] want;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: got %h, expected no event", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  initial begin
    logic [NUM_REQ-1:0] prev_g;
    prev_g = '0;
    forever begin
      @(posedge clk);
      #2;
      if (done != '0)
        check_evt("done_evt", pack_evt(cyc, K_DONE, busy, done, int'(count)));
      else if (grant == '0 && prev_g != '0)
        check_evt("end_evt", pack_evt(cyc, K_END, busy, prev_g, int'(count)));
      if (grant != '0 && prev_g == '0)
        check_evt("grant_evt", pack_evt(cyc, K_GRANT, busy, grant, int'(count)));
      prev_g = grant;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NUM_REQ-1:0] rq;
    rst = 1'b1; req = '0; tick = 1'b0; abort = 1'b0; load_val = '0;
    for (int i = 0; i < NUM_REQ; i++) lv[i] = 1;

    for (int k = 0; k < 3; k++) cycle('0, 1'b0, 1'b0, 1'b1);
    check_reset_outputs();

    // single request, load 3
    lv[2] = 3;
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    idle(7);

    // round robin over all requesters, load 1
    for (int i = 0; i < NUM_REQ; i++) lv[i] = 1;
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    idle(16);

    // tick gating 1,0,0,1,1 on load 2
    lv[0] = 2;
    cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0, 1'b0);
    idle(4);

    // abort at count 3 with req[1] arriving alongside
    lv[0] = 5;
    lv[1] = 1;
    cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle(4'b0010, 1'b1, 1'b1, 1'b0);
    idle(6);

    // zero load with req[0] held, req[1] queued behind it
    lv[0] = 0;
    lv[1] = 2;
    cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    cycle(4'b0011, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    idle(6);

    // reset while running at count 4, then a fresh req[3]
    lv[3] = 6;
    cycle(4'b1000, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle(4'b0100, 1'b1, 1'b0, 1'b1);
    check_reset_outputs();
    cycle(4'b1000, 1'b1, 1'b0, 1'b0);
    idle(10);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      rq = '0;
      for (int i = 0; i < NUM_REQ; i++) rq[i] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) lv[$urandom_range(0, NUM_REQ-1)] = $urandom_range(0, 6);
      cycle(rq, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 199) == 0));
    end
    idle(40);

    @(posedge clk);
    #3;
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
